// File: rtl/pacman_move_ctrl.sv
// pacman_move_ctrl: tile-level Pac-Man movement sequencer.
// Buffers button directions. On each game tick it queries the shared maze wall
// memory and steps the tile coordinate. The buffered direction is tried before
// the current one. Maze edges wrap around as tunnels.

module pacman_move_ctrl #(
    parameter int TICK_DIV = 5_000_000,
    parameter int GRID_W   = 28,
    parameter int GRID_H   = 31,
    parameter int START_X  = 13,
    parameter int START_Y  = 23
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       scen_up,
    input  logic       scen_down,
    input  logic       scen_left,
    input  logic       scen_right,
    output logic       wall_req,
    output logic [4:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_data,
    output logic [4:0] pac_x,
    output logic [4:0] pac_y,
    output logic [1:0] cur_dir,
    output logic       moving,
    output logic       move_pulse,
    output logic       tick_overrun
);

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]       X_LAST    = 5'(GRID_W - 1);
    localparam logic [4:0]       Y_LAST    = 5'(GRID_H - 1);
    localparam logic [4:0]       X_START   = 5'(START_X);
    localparam logic [4:0]       Y_START   = 5'(START_Y);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ_NEXT,
        REQ_CUR,
        STEP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tick_count;
    logic             tick;
    logic             tick_pend;
    logic [1:0]       next_dir;
    logic             next_valid;
    logic [1:0]       btn_dir;
    logic             btn_any;
    logic [1:0]       req_dir;
    logic [1:0]       lookup_dir;
    logic [4:0]       lookup_x;
    logic [4:0]       lookup_y;
    logic             ack_ok;
    logic             clear_pend;
    logic             take_next;
    logic             commit_step;
    logic             block_cur;
    logic             req_hold;

    // Neighbouring tile in a direction. Edges wrap with explicit compares so
    // the tunnels work for any grid size that fits in 5 bits.
    function automatic logic [9:0] neighbour(input logic [4:0] x, input logic [4:0] y,
                                             input logic [1:0] dir);
        logic [4:0] nx;
        logic [4:0] ny;
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = (y == 5'd0)   ? Y_LAST : y - 5'd1;
            DIR_DOWN:  ny = (y == Y_LAST) ? 5'd0   : y + 5'd1;
            DIR_LEFT:  nx = (x == 5'd0)   ? X_LAST : x - 5'd1;
            default:   nx = (x == X_LAST) ? 5'd0   : x + 5'd1;
        endcase
        return {nx, ny};
    endfunction

    // Resolve simultaneous button pulses with up > down > left > right priority
    always_comb begin
        btn_any = scen_up | scen_down | scen_left | scen_right;
        if (scen_up) begin
            btn_dir = DIR_UP;
        end else if (scen_down) begin
            btn_dir = DIR_DOWN;
        end else if (scen_left) begin
            btn_dir = DIR_LEFT;
        end else begin
            btn_dir = DIR_RIGHT;
        end
    end

    assign tick = (tick_count == TICK_LAST);

    // Game-tick divider, pending-tick flag and sticky overrun detection
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            tick_count   <= '0;
            tick_pend    <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            tick_count <= tick ? '0 : tick_count + CNT_W'(1);
            if (tick) begin
                if (tick_pend && !clear_pend) begin
                    tick_overrun <= 1'b1;
                end
                tick_pend <= 1'b1;
            end else if (clear_pend) begin
                tick_pend <= 1'b0;
            end
        end
    end

    // Direction buffer: a fresh pulse beats consumption. A direction that was overwritten mid-lookup stays buffered.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            next_dir   <= DIR_UP;
            next_valid <= 1'b0;
        end else if (btn_any) begin
            next_dir   <= btn_dir;
            next_valid <= 1'b1;
        end else if (take_next && (next_dir == req_dir)) begin
            next_valid <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        state_next  = state;
        clear_pend  = 1'b0;
        take_next   = 1'b0;
        commit_step = 1'b0;
        block_cur   = 1'b0;
        ack_ok      = wall_req & wall_ack;
        case (state)
            IDLE: begin
                if (tick_pend) begin
                    clear_pend = 1'b1;
                    if (next_valid) begin
                        state_next = REQ_NEXT;
                    end else if (moving) begin
                        state_next = REQ_CUR;
                    end
                end
            end
            REQ_NEXT: begin
                if (ack_ok) begin
                    if (!wall_data) begin
                        take_next   = 1'b1;
                        commit_step = 1'b1;
                        state_next  = STEP;
                    end else begin
                        state_next = moving ? REQ_CUR : IDLE;
                    end
                end
            end
            REQ_CUR: begin
                if (ack_ok) begin
                    if (!wall_data) begin
                        commit_step = 1'b1;
                        state_next  = STEP;
                    end else begin
                        block_cur  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        req_hold = ((state_next == REQ_NEXT) || (state_next == REQ_CUR)) && !ack_ok;
    end

    // Lookup target for whichever direction the upcoming request will test
    always_comb begin
        lookup_dir           = (state_next == REQ_NEXT) ? next_dir : cur_dir;
        {lookup_x, lookup_y} = neighbour(pac_x, pac_y, lookup_dir);
    end

    // Registered wall request. The address and tested direction are latched when the request opens.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            wall_req <= 1'b0;
            wall_x   <= 5'd0;
            wall_y   <= 5'd0;
            req_dir  <= DIR_LEFT;
        end else begin
            wall_req <= req_hold;
            if (req_hold && !wall_req) begin
                wall_x  <= lookup_x;
                wall_y  <= lookup_y;
                req_dir <= lookup_dir;
            end
        end
    end

    // Tile coordinate, heading and motion status. The looked-up tile becomes the new position.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            pac_x      <= X_START;
            pac_y      <= Y_START;
            cur_dir    <= DIR_LEFT;
            moving     <= 1'b0;
            move_pulse <= 1'b0;
        end else begin
            move_pulse <= commit_step;
            if (commit_step) begin
                pac_x  <= wall_x;
                pac_y  <= wall_y;
                moving <= 1'b1;
            end
            if (take_next) begin
                cur_dir <= req_dir;
            end
            if (block_cur) begin
                moving <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// tb_pacman_move_ctrl: runs directed scenarios, then a randomized run.
// A tick-level Pac-Man model and a wall-memory responder with random ack
// delay are used as the reference.

module tb_pacman_move_ctrl;

    localparam int TICK_DIV = 16;
    localparam int GRID_W   = 28;
    localparam int GRID_H   = 31;
    localparam int START_X  = 13;
    localparam int START_Y  = 23;

    logic       board_clk = 1'b0;
    logic       Reset;
    logic       scen_up;
    logic       scen_down;
    logic       scen_left;
    logic       scen_right;
    logic       wall_req;
    logic [4:0] wall_x;
    logic [4:0] wall_y;
    logic       wall_ack;
    logic       wall_data;
    logic [4:0] pac_x;
    logic [4:0] pac_y;
    logic [1:0] cur_dir;
    logic       moving;
    logic       move_pulse;
    logic       tick_overrun;

    int total = 0;
    int bad   = 0;

    // maze and responder controls
    bit walls [GRID_W][GRID_H];
    bit auto_ack   = 1'b1;
    bit manual_ack = 1'b0;
    int max_delay  = 0;
    bit busy       = 1'b0;
    int delay_left = 0;
    int addr_q[$];

    // activity monitor
    int cyc            = 0;
    int tb_count       = 0;
    int last_tick_cyc  = 0;
    int last_pulse_cyc = 0;
    int pulse_count    = 0;

    // reference model state
    int m_x, m_y, m_dir, m_next_dir;
    bit m_moving, m_next_valid;
    bit exp_moved;
    int exp_addr[$];

    pacman_move_ctrl #(
        .TICK_DIV (TICK_DIV),
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .START_X  (START_X),
        .START_Y  (START_Y)
    ) dut (
        .board_clk    (board_clk),
        .Reset        (Reset),
        .scen_up      (scen_up),
        .scen_down    (scen_down),
        .scen_left    (scen_left),
        .scen_right   (scen_right),
        .wall_req     (wall_req),
        .wall_x       (wall_x),
        .wall_y       (wall_y),
        .wall_ack     (wall_ack),
        .wall_data    (wall_data),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .cur_dir      (cur_dir),
        .moving       (moving),
        .move_pulse   (move_pulse),
        .tick_overrun (tick_overrun)
    );

    // 100 MHz board clock
    always #5 board_clk = ~board_clk;

    // Game-tick schedule: a tick every TICK_DIV cycles counted from reset release
    always @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            tb_count <= 0;
        end else begin
            tb_count <= (tb_count == TICK_DIV - 1) ? 0 : tb_count + 1;
            cyc      <= cyc + 1;
        end
    end

    // Record tick cycles and move strobes, sampled mid-cycle
    always @(negedge board_clk) begin
        if (tb_count == TICK_DIV - 1) last_tick_cyc = cyc;
        if (move_pulse === 1'b1) begin
            pulse_count++;
            last_pulse_cyc = cyc;
        end
    end

    // Wall memory responder: acks one or more cycles after the request and logs each address
    always @(negedge board_clk) begin
        if (Reset) begin
            wall_ack  = 1'b0;
            wall_data = 1'b0;
            busy      = 1'b0;
        end else if (!auto_ack) begin
            wall_ack  = manual_ack;
            wall_data = 1'b0;
        end else if (wall_ack) begin
            wall_ack = 1'b0;
        end else if (wall_req === 1'b1) begin
            if (!busy) begin
                busy       = 1'b1;
                delay_left = $urandom_range(0, max_delay);
            end else if (delay_left == 0) begin
                busy      = 1'b0;
                wall_ack  = 1'b1;
                wall_data = (wall_x < GRID_W && wall_y < GRID_H) ? walls[wall_x][wall_y] : 1'b1;
                addr_q.push_back(int'(wall_x) * 32 + int'(wall_y));
            end else begin
                delay_left--;
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge board_clk);
        #1;
    endtask

    task automatic modelReset();
        m_x          = START_X;
        m_y          = START_Y;
        m_dir        = 2;
        m_moving     = 1'b0;
        m_next_dir   = 0;
        m_next_valid = 1'b0;
    endtask

    task automatic modelNeighbour(input int x, input int y, input int dir, output int nx, output int ny);
        int dx = 0;
        int dy = 0;
        case (dir)
            0: dy = -1;
            1: dy = 1;
            2: dx = -1;
            default: dx = 1;
        endcase
        nx = (x + dx + GRID_W) % GRID_W;
        ny = (y + dy + GRID_H) % GRID_H;
    endtask

    // One game tick at the level of "try buffered, then current direction"
    task automatic modelTick();
        int nx, ny;
        exp_addr.delete();
        exp_moved = 1'b0;
        if (m_next_valid) begin
            modelNeighbour(m_x, m_y, m_next_dir, nx, ny);
            exp_addr.push_back(nx * 32 + ny);
            if (!walls[nx][ny]) begin
                m_dir        = m_next_dir;
                m_next_valid = 1'b0;
                m_x          = nx;
                m_y          = ny;
                m_moving     = 1'b1;
                exp_moved    = 1'b1;
                return;
            end
        end
        if (!m_moving) return;
        modelNeighbour(m_x, m_y, m_dir, nx, ny);
        exp_addr.push_back(nx * 32 + ny);
        if (walls[nx][ny]) begin
            m_moving = 1'b0;
        end else begin
            m_x       = nx;
            m_y       = ny;
            exp_moved = 1'b1;
        end
    endtask

    task automatic applyReset();
        Reset      = 1'b1;
        scen_up    = 1'b0;
        scen_down  = 1'b0;
        scen_left  = 1'b0;
        scen_right = 1'b0;
        repeat (3) stepCycle();
        Reset = 1'b0;
        modelReset();
        stepCycle();
    endtask

    // One-cycle button pulse(s), mirrored into the model's direction buffer
    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r);
        scen_up    = u;
        scen_down  = d;
        scen_left  = l;
        scen_right = r;
        stepCycle();
        scen_up    = 1'b0;
        scen_down  = 1'b0;
        scen_left  = 1'b0;
        scen_right = 1'b0;
        if (u | d | l | r) begin
            m_next_valid = 1'b1;
            m_next_dir   = u ? 0 : d ? 1 : l ? 2 : 3;
        end
    endtask

    // Wait for the next tick cycle, then long enough for its processing to finish
    task automatic runTick();
        int guard = 0;
        while (tb_count != TICK_DIV - 1 && guard < 3 * TICK_DIV) begin
            stepCycle();
            guard++;
        end
        repeat (13) stepCycle();
    endtask

    task automatic tickAndCheck(input string tag, input int exp_lat);
        int pulses_before;
        addr_q.delete();
        pulses_before = pulse_count;
        modelTick();
        runTick();
        checkOutput({tag, ".pac_x"}, pac_x, m_x);
        checkOutput({tag, ".pac_y"}, pac_y, m_y);
        checkOutput({tag, ".cur_dir"}, cur_dir, m_dir);
        checkOutput({tag, ".moving"}, moving, m_moving);
        checkOutput({tag, ".pulses"}, pulse_count - pulses_before, exp_moved ? 1 : 0);
        checkOutput({tag, ".lookups"}, addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < addr_q.size()) checkOutput({tag, ".addr"}, addr_q[i], exp_addr[i]);
        end
        if (exp_lat >= 0 && exp_moved) begin
            checkOutput({tag, ".latency"}, last_pulse_cyc - last_tick_cyc, exp_lat);
        end
        checkOutput({tag, ".overrun"}, tick_overrun, 0);
    endtask

    task automatic randomWalls(input int pct);
        for (int x = 0; x < GRID_W; x++) begin
            for (int y = 0; y < GRID_H; y++) begin
                walls[x][y] = ($urandom_range(0, 99) < pct);
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".pac_x"}, pac_x, START_X);
        checkOutput({tag, ".pac_y"}, pac_y, START_Y);
        checkOutput({tag, ".cur_dir"}, cur_dir, 2);
        checkOutput({tag, ".moving"}, moving, 0);
        checkOutput({tag, ".move_pulse"}, move_pulse, 0);
        checkOutput({tag, ".wall_req"}, wall_req, 0);
        checkOutput({tag, ".wall_x"}, wall_x, 0);
        checkOutput({tag, ".wall_y"}, wall_y, 0);
        checkOutput({tag, ".overrun"}, tick_overrun, 0);
    endtask

    initial begin
        int guard;
        int btn;
        randomWalls(0);
        max_delay = 0;
        applyReset();
        checkResetValues("reset");

        // an ack with no request outstanding must do nothing
        auto_ack   = 1'b0;
        manual_ack = 1'b1;
        repeat (2) stepCycle();
        manual_ack = 1'b0;
        stepCycle();
        auto_ack = 1'b1;
        checkOutput("stray_ack.wall_req", wall_req, 0);
        checkOutput("stray_ack.moving", moving, 0);
        checkOutput("stray_ack.pac_x", pac_x, START_X);

        // idle tick: nothing buffered, not moving, no lookup
        tickAndCheck("idle_tick", -1);

        // buffered left from rest, then current-direction move
        applyStimulus(0, 0, 1, 0);
        tickAndCheck("first_left", 4);
        checkOutput("first_left.x12", pac_x, 12);
        tickAndCheck("cur_move", 4);

        // buffered up blocked, left still open; up retried next tick
        walls[11][22] = 1'b1;
        applyStimulus(1, 0, 0, 0);
        tickAndCheck("up_blocked", 7);
        tickAndCheck("up_retry", 4);
        checkOutput("up_retry.dir", cur_dir, 0);

        // simultaneous up and right resolve to up
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        tickAndCheck("up_right", 4);
        checkOutput("up_right.dir", cur_dir, 0);

        // current direction walled, nothing buffered
        walls[m_x][m_y - 1] = 1'b1;
        tickAndCheck("blocked", -1);
        tickAndCheck("stopped", -1);

        // horizontal tunnel
        applyStimulus(0, 0, 1, 0);
        guard = 0;
        while (m_x != 0 && guard < 40) begin
            tickAndCheck("walk_left", 4);
            guard++;
        end
        tickAndCheck("wrap_left", 4);
        checkOutput("wrap_left.x27", pac_x, GRID_W - 1);
        applyStimulus(0, 0, 0, 1);
        tickAndCheck("wrap_right", 4);
        checkOutput("wrap_right.x0", pac_x, 0);

        // vertical tunnel
        applyStimulus(1, 0, 0, 0);
        guard = 0;
        while (m_y != 0 && guard < 40) begin
            tickAndCheck("walk_up", 4);
            guard++;
        end
        tickAndCheck("wrap_up", 4);
        checkOutput("wrap_up.y30", pac_y, GRID_H - 1);
        applyStimulus(0, 1, 0, 0);
        tickAndCheck("wrap_down", 4);
        checkOutput("wrap_down.y0", pac_y, 0);

        // stalled memory: first late tick pends, the second overruns, and it sticks
        auto_ack   = 1'b0;
        manual_ack = 1'b0;
        runTick();
        checkOutput("stall.wall_req", wall_req, 1);
        checkOutput("stall.no_overrun", tick_overrun, 0);
        runTick();
        checkOutput("stall.one_pending", tick_overrun, 0);
        runTick();
        checkOutput("stall.overrun", tick_overrun, 1);
        runTick();
        checkOutput("stall.sticky", tick_overrun, 1);
        checkOutput("stall.still_req", wall_req, 1);

        // reset in the middle of the abandoned request
        Reset = 1'b1;
        #1;
        checkResetValues("mid_req_reset");
        repeat (2) stepCycle();
        Reset = 1'b0;
        modelReset();
        auto_ack = 1'b1;
        stepCycle();
        checkResetValues("after_reset");

        // randomized run against the model with variable ack latency
        max_delay = 2;
        randomWalls(25);
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 9) == 0) randomWalls(25);
            if ($urandom_range(0, 9) < 6) begin
                btn = $urandom_range(1, 15);
                applyStimulus(btn[3], btn[2], btn[1], btn[0]);
            end
            tickAndCheck("rand", -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
